// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: trap sequencer between the CLINT, the CSR file and execute.
// Takes timer/software interrupts, writes mepc/mcause/mstatus on consecutive
// cycles, then redirects fetch to mtvec. Also sequences mret.
//
// state         | meaning
// --------------+--------------------------------------------------------
// S_IDLE        | watching for a taken interrupt or an mret in execute
// S_WR_MEPC     | writing mepc with the latched trap PC
// S_WR_MCAUSE   | writing mcause with the latched cause
// S_WR_MSTATUS  | writing mstatus: MPIE<=MIE, MIE<=0, MPP<=M
// S_JUMP        | redirecting fetch to the mtvec target
// S_MRET_MSTAT  | writing mstatus: MIE<=MPIE, MPIE<=1
// S_MRET_JUMP   | redirecting fetch to mepc

module irq_trap_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  timer_irq_i,
    input  logic                  software_irq_i,
    input  logic                  inst_valid_i,
    input  logic [DATA_WIDTH-1:0] inst_addr_i,
    input  logic                  mret_i,
    input  logic [DATA_WIDTH-1:0] mstatus_i,
    input  logic [DATA_WIDTH-1:0] mie_i,
    input  logic [DATA_WIDTH-1:0] mtvec_i,
    input  logic [DATA_WIDTH-1:0] mepc_i,
    output logic                  hold_o,
    output logic                  csr_we_o,
    output logic [11:0]           csr_waddr_o,
    output logic [DATA_WIDTH-1:0] csr_wdata_o,
    output logic                  jump_o,
    output logic [DATA_WIDTH-1:0] jump_addr_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [DATA_WIDTH-1:0] CAUSE_SW = {1'b1, (DATA_WIDTH-1)'(3)};
    localparam logic [DATA_WIDTH-1:0] CAUSE_TM = {1'b1, (DATA_WIDTH-1)'(7)};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_MEPC    = 3'd1,
        S_WR_MCAUSE  = 3'd2,
        S_WR_MSTATUS = 3'd3,
        S_JUMP       = 3'd4,
        S_MRET_MSTAT = 3'd5,
        S_MRET_JUMP  = 3'd6
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_cause;

    logic                  w_idle;
    logic                  w_pend_sw;
    logic                  w_pend_tm;
    logic                  w_take;
    logic                  w_mret_go;
    logic [DATA_WIDTH-1:0] w_mst_trap;
    logic [DATA_WIDTH-1:0] w_mst_mret;
    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_trap_target;
    logic                  w_unused;

    assign w_idle    = (r_state == S_IDLE);
    assign w_pend_sw = software_irq_i & mie_i[3];
    assign w_pend_tm = timer_irq_i & mie_i[7];
    assign w_take    = w_idle & inst_valid_i & mstatus_i[3] & (w_pend_sw | w_pend_tm);
    // An interrupt wins over a simultaneous mret; the mret re-executes later.
    assign w_mret_go = w_idle & inst_valid_i & mret_i & ~w_take;

    assign w_unused = ^{mie_i[DATA_WIDTH-1:8], mie_i[6:4], mie_i[2:0],
                        r_cause[DATA_WIDTH-1:DATA_WIDTH-2]};

    // mstatus images written on trap entry and on mret.
    always_comb begin
        w_mst_trap        = mstatus_i;
        w_mst_trap[7]     = mstatus_i[3];
        w_mst_trap[3]     = 1'b0;
        w_mst_trap[12:11] = 2'b11;
        w_mst_mret        = mstatus_i;
        w_mst_mret[3]     = mstatus_i[7];
        w_mst_mret[7]     = 1'b1;
    end

    // Trap target: vectored only for mode 1; modes 0/2/3 are direct.
    // Offset is 4*cause[DW-2:0] modulo 2^DW, so only cause[DW-3:0] matters.
    always_comb begin
        w_base = {mtvec_i[DATA_WIDTH-1:2], 2'b00};
        if (mtvec_i[1:0] == 2'b01) begin
            w_trap_target = w_base + {r_cause[DATA_WIDTH-3:0], 2'b00};
        end else begin
            w_trap_target = w_base;
        end
    end

    // Sequencer state, trap PC and cause latches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cause <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_pc    <= inst_addr_i;
                        r_cause <= w_pend_sw ? CAUSE_SW : CAUSE_TM;
                        r_state <= S_WR_MEPC;
                    end else if (w_mret_go) begin
                        r_state <= S_MRET_MSTAT;
                    end
                end
                S_WR_MEPC:    r_state <= S_WR_MCAUSE;
                S_WR_MCAUSE:  r_state <= S_WR_MSTATUS;
                S_WR_MSTATUS: r_state <= S_JUMP;
                S_JUMP:       r_state <= S_IDLE;
                S_MRET_MSTAT: r_state <= S_MRET_JUMP;
                S_MRET_JUMP:  r_state <= S_IDLE;
                default:      r_state <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the CSR write port and fetch redirect; zero when idle.
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        case (r_state)
            S_WR_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = r_pc;
            end
            S_WR_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = r_cause;
            end
            S_WR_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = w_mst_trap;
            end
            S_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = w_trap_target;
            end
            S_MRET_MSTAT: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = w_mst_mret;
            end
            S_MRET_JUMP: begin
                jump_o      = 1'b1;
                jump_addr_o = mepc_i;
            end
            default: begin
                csr_we_o = 1'b0;
            end
        endcase
    end

    // Stall covers the detect cycle combinationally; forced low in reset.
    assign hold_o = rst_i & (w_take | (w_idle & inst_valid_i & mret_i) | ~w_idle);

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: directed scenarios plus a random run
// compared against a queue-of-actions reference model.

module tb_irq_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tm, sw, valid, mret;
    logic [31:0] addr, mstatus, mie, mtvec, mepc;
    logic        hold_o, csr_we_o, jump_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o, jump_addr_o;

    int checks   = 0;
    int failures = 0;

    irq_trap_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .timer_irq_i(tm), .software_irq_i(sw),
        .inst_valid_i(valid), .inst_addr_i(addr), .mret_i(mret),
        .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
        .hold_o(hold_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        jump;
        logic [31:0] jaddr;
    } out_t;

    typedef enum {A_MEPC, A_MCAUSE, A_MST, A_JUMP, A_RMST, A_RJUMP} act_e;
    typedef struct {
        act_e        k;
        logic [31:0] v;
    } act_t;

    act_t q[$];

    function automatic out_t get_obs();
        return {hold_o, csr_we_o, csr_waddr_o, csr_wdata_o, jump_o, jump_addr_o};
    endfunction

    // Reference: a taken trap or mret queues its remaining cycles as actions.
    task automatic model_eval(output out_t e);
        act_t        a;
        logic        psw, ptm, take;
        logic [31:0] c;
        e = '0;
        if (!rst) begin
            q.delete();
            return;
        end
        if (q.size() == 0) begin
            psw  = sw & mie[3];
            ptm  = tm & mie[7];
            take = valid & mstatus[3] & (psw | ptm);
            if (take) begin
                c = psw ? 32'h8000_0003 : 32'h8000_0007;
                q.push_back('{A_MEPC, addr});
                q.push_back('{A_MCAUSE, c});
                q.push_back('{A_MST, 32'h0});
                q.push_back('{A_JUMP, c});
                e.hold = 1'b1;
            end else if (valid & mret) begin
                q.push_back('{A_RMST, 32'h0});
                q.push_back('{A_RJUMP, 32'h0});
                e.hold = 1'b1;
            end
        end else begin
            a = q.pop_front();
            e.hold = 1'b1;
            case (a.k)
                A_MEPC:   begin e.we = 1; e.addr = 12'h341; e.data = a.v; end
                A_MCAUSE: begin e.we = 1; e.addr = 12'h342; e.data = a.v; end
                A_MST: begin
                    e.we = 1; e.addr = 12'h300;
                    e.data = (mstatus & ~32'h1888) | 32'h1800 | (mstatus[3] ? 32'h80 : 32'h0);
                end
                A_JUMP: begin
                    e.jump = 1;
                    if (mtvec[1:0] == 2'b01)
                        e.jaddr = (mtvec & ~32'h3) + (a.v & 32'h7fff_ffff) * 32'd4;
                    else
                        e.jaddr = mtvec & ~32'h3;
                end
                A_RMST: begin
                    e.we = 1; e.addr = 12'h300;
                    e.data = (mstatus & ~32'h88) | 32'h80 | (mstatus[7] ? 32'h8 : 32'h0);
                end
                default: begin e.jump = 1; e.jaddr = mepc; end
            endcase
        end
    endtask

    // Sample at negedge, step model, return at posedge+1 ready for new inputs.
    task automatic run_cycle(output out_t e, output out_t o);
        @(negedge clk);
        o = get_obs();
        model_eval(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_inputs();
        tm = 0; sw = 0; valid = 0; mret = 0; addr = 0;
        mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    endtask

    task automatic test_reset();
        out_t e, o;
        rst = 0; tm = 1; sw = 1; valid = 1; mret = 1; addr = 32'h1234;
        mstatus = 32'h8; mie = 32'h88; mtvec = 32'h101; mepc = 32'h55;
        #1;
        o = get_obs();
        checks++;
        if (o !== '0) begin
            failures++; $display("FAIL reset_outputs got %h want 0", o);
        end
        for (int i = 0; i < 2; i++) begin
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL reset_hold cyc %0d got %h want %h", i, o, e);
            end
        end
        set_idle_inputs();
        rst = 1;
        run_cycle(e, o);
    endtask

    task automatic test_timer_direct();
        out_t e, o;
        logic ok;
        valid = 1; addr = 32'h2000; mstatus = 32'h8; mie = 32'h80; mtvec = 32'h100; tm = 1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) tm = 0;
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL timer_direct_model cyc %0d got %h want %h", i, o, e);
            end
            case (i)
                0: ok = o.hold && !o.we && !o.jump;
                1: ok = o.hold && o.we && o.addr == 12'h341 && o.data == 32'h2000;
                2: ok = o.hold && o.we && o.addr == 12'h342 && o.data == 32'h8000_0007;
                3: ok = o.hold && o.we && o.addr == 12'h300 && o.data == 32'h1880;
                4: ok = o.hold && !o.we && o.jump && o.jaddr == 32'h100;
                default: ok = !o.hold && !o.we && !o.jump;
            endcase
            checks++;
            if (!ok) begin
                failures++; $display("FAIL timer_direct_plan cyc %0d got %h", i, o);
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_vectored();
        out_t e, o;
        logic ok;
        valid = 1; addr = 32'h2400; mstatus = 32'h8; mie = 32'h88; mtvec = 32'h101;
        tm = 1; sw = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin tm = 0; sw = 0; end
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL vectored_model cyc %0d got %h want %h", i, o, e);
            end
            ok = 1'b1;
            if (i == 2) ok = o.we && o.addr == 12'h342 && o.data == 32'h8000_0003;
            if (i == 4) ok = o.jump && o.jaddr == 32'h10C;
            checks++;
            if (!ok) begin
                failures++; $display("FAIL vectored_plan cyc %0d got %h", i, o);
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_masked();
        out_t e, o;
        for (int cfg = 0; cfg < 3; cfg++) begin
            tm = 1; sw = 1; addr = 32'h3000; mtvec = 32'h100;
            valid   = (cfg != 2);
            mstatus = (cfg == 0) ? 32'h0 : 32'h8;
            mie     = (cfg == 1) ? 32'h0 : 32'h88;
            for (int i = 0; i < 20; i++) begin
                run_cycle(e, o);
                checks++;
                if (o !== e || o.hold || o.we || o.jump) begin
                    failures++;
                    $display("FAIL masked cfg %0d cyc %0d got %h want %h", cfg, i, o, e);
                end
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_mret();
        out_t e, o;
        logic ok;
        valid = 1; addr = 32'h2100; mret = 1; mstatus = 32'h1880; mepc = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) mret = 0;
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL mret_model cyc %0d got %h want %h", i, o, e);
            end
            case (i)
                0: ok = o.hold && !o.we && !o.jump;
                1: ok = o.hold && o.we && o.addr == 12'h300 && o.data == 32'h1888;
                2: ok = o.hold && !o.we && o.jump && o.jaddr == 32'h2000;
                default: ok = !o.hold && !o.we && !o.jump;
            endcase
            checks++;
            if (!ok) begin
                failures++; $display("FAIL mret_plan cyc %0d got %h", i, o);
            end
        end
        // mret and timer in the same cycle: interrupt wins, mepc = mret PC
        addr = 32'h3000; mret = 1; tm = 1; mstatus = 32'h8; mie = 32'h80; mtvec = 32'h200;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin mret = 0; tm = 0; end
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL mret_irq_model cyc %0d got %h want %h", i, o, e);
            end
            ok = 1'b1;
            if (i == 1) ok = o.we && o.addr == 12'h341 && o.data == 32'h3000;
            if (i == 4) ok = o.jump && o.jaddr == 32'h200;
            checks++;
            if (!ok) begin
                failures++; $display("FAIL mret_irq_plan cyc %0d got %h", i, o);
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        valid = 1; addr = 32'h4000; mstatus = 32'h8; mie = 32'h80; mtvec = 32'h100; tm = 1;
        run_cycle(e, o);
        run_cycle(e, o);
        o = get_obs();
        checks++;
        if (!(o.we && o.addr == 12'h342)) begin
            failures++; $display("FAIL reset_mid_pre got %h want mcause write", o);
        end
        rst = 0;
        #1;
        o = get_obs();
        checks++;
        if (o !== '0) begin
            failures++; $display("FAIL reset_mid_async got %h want 0", o);
        end
        for (int i = 0; i < 2; i++) begin
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL reset_mid_held cyc %0d got %h want %h", i, o, e);
            end
        end
        rst = 1; tm = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(e, o);
            checks++;
            if (o !== e || o.hold || o.we || o.jump) begin
                failures++; $display("FAIL reset_mid_after cyc %0d got %h want %h", i, o, e);
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_pulse();
        out_t e, o;
        logic ok;
        valid = 1; addr = 32'h5004; mstatus = 32'h8; mie = 32'h80; mtvec = 32'h180; tm = 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) tm = 0;
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL pulse_model cyc %0d got %h want %h", i, o, e);
            end
            ok = 1'b1;
            if (i == 2) ok = o.we && o.addr == 12'h342 && o.data == 32'h8000_0007;
            if (i == 4) ok = o.jump && o.jaddr == 32'h180;
            if (i == 5) ok = !o.hold;
            checks++;
            if (!ok) begin
                failures++; $display("FAIL pulse_plan cyc %0d got %h", i, o);
            end
        end
        set_idle_inputs();
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        logic ok;
        valid = 1; addr = 32'h6000; mstatus = 32'h8; mie = 32'h8; mtvec = 32'h300; sw = 1;
        for (int i = 0; i < 11; i++) begin
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL b2b_model cyc %0d got %h want %h", i, o, e);
            end
            ok = 1'b1;
            if (i == 5) ok = o.hold && !o.we && !o.jump;
            if (i == 6) ok = o.we && o.addr == 12'h341 && o.data == 32'h6000;
            checks++;
            if (!ok) begin
                failures++; $display("FAIL b2b_plan cyc %0d got %h", i, o);
            end
        end
        set_idle_inputs();
        for (int i = 0; i < 5; i++) run_cycle(e, o);
    endtask

    task automatic test_random();
        out_t e, o;
        int   errs = 0;
        for (int i = 0; i < 600; i++) begin
            sw      = ($urandom % 4) == 0;
            tm      = ($urandom % 3) == 0;
            valid   = ($urandom % 4) != 0;
            mret    = ($urandom % 5) == 0;
            addr    = $urandom;
            mstatus = $urandom;
            mstatus[3] = ($urandom % 10) < 7;
            mie     = $urandom;
            mtvec   = $urandom;
            mepc    = $urandom;
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++;
                if (errs < 10) $display("FAIL random cyc %0d got %h want %h", i, o, e);
                errs++;
            end
        end
        set_idle_inputs();
        for (int i = 0; i < 6; i++) begin
            run_cycle(e, o);
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL random_drain cyc %0d got %h want %h", i, o, e);
            end
        end
    endtask

    initial begin
        rst = 0;
        set_idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_timer_direct();
        test_vectored();
        test_masked();
        test_mret();
        test_reset_mid();
        test_pulse();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
